// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// After reset the block walks every register once to load its init value,
// then raises ready and serves combinational reads with write-through bypass.
module regfile_sb #(
   parameter int REGISTER_WIDTH      = 32,
   parameter int REGISTER_ADDR_WIDTH = 5,
   parameter int NUM_RD              = 2,
   parameter int NUM_WR              = 2,
   parameter int INIT_STYLE          = 2
) (
   input  logic                                  cpu_clk,
   input  logic                                  cpu_rst,
   input  logic [NUM_RD*REGISTER_ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*REGISTER_WIDTH-1:0]      rd_data,
   output logic [NUM_RD-1:0]                     rd_busy,
   input  logic [NUM_WR-1:0]                     wr_en,
   input  logic [NUM_WR*REGISTER_ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*REGISTER_WIDTH-1:0]      wr_data,
   input  logic                                  iss_valid,
   input  logic [REGISTER_ADDR_WIDTH-1:0]        iss_addr,
   input  logic                                  flush,
   output logic                                  ready
);

   localparam int AW    = REGISTER_ADDR_WIDTH;
   localparam int W     = REGISTER_WIDTH;
   localparam int D     = 2**AW;
   localparam int PRODW = W + AW + 2;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          state;
   logic [AW-1:0]   init_cnt;
   logic [D-1:0]    busy;
   logic [D-1:0]    busy_nxt;
   logic [W-1:0]    regs [D];

   // Init value for register idx, computed wide and then truncated to W bits.
   function automatic logic [W-1:0] init_value(input logic [AW-1:0] idx);
      logic [PRODW-1:0] wide;
      wide = PRODW'(idx);
      if (INIT_STYLE == 0) begin
         return wide[W-1:0];
      end else if (INIT_STYLE == 1) begin
         wide = wide * PRODW'(3);
         return wide[W-1:0];
      end else begin
         return '0;
      end
   endfunction

   // Next busy vector: write-backs clear, issue sets (and wins), flush clears all.
   always_comb begin
      busy_nxt = busy;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
            busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
         end
      end
      if (flush) begin
         busy_nxt = '0;
      end else if (iss_valid && (iss_addr != '0)) begin
         busy_nxt[iss_addr] = 1'b1;
      end
   end

   // Control FSM: INIT sweeps the init counter, RUN owns the scoreboard.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         ready    <= 1'b0;
         busy     <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (&init_cnt) begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end
            end
            ST_RUN: begin
               busy <= busy_nxt;
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

   // Register storage: init sweep, then port writes with the highest port winning.
   always_ff @(posedge cpu_clk) begin
      if (state == ST_INIT) begin
         regs[init_cnt] <= init_value(init_cnt);
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*W +: W];
            end
         end
      end
   end

   // Combinational read ports with write-through bypass of data and busy clear.
   always_comb begin
      logic [AW-1:0] ra;
      logic [W-1:0]  rv;
      logic          hit;
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rv      = '0;
      hit     = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra  = rd_addr[k*AW +: AW];
         rv  = regs[ra];
         hit = 1'b0;
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
               hit = 1'b1;
               rv  = wr_data[j*W +: W];
            end
         end
         if ((state == ST_RUN) && (ra != '0)) begin
            rd_data[k*W +: W] = rv;
            rd_busy[k]        = busy[ra] & ~hit;
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: stimulus pushes expected outputs from a behavioural
// model into a queue; a monitor on the falling edge pops and compares.
module tb_regfile_sb;

   localparam int W  = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int D  = 32;

   logic              cpu_clk = 1'b0;
   logic              cpu_rst;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*W-1:0]   rd_data;
   logic [NR-1:0]     rd_busy;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*W-1:0]   wr_data;
   logic              iss_valid;
   logic [AW-1:0]     iss_addr;
   logic              flush;
   logic              ready;

   regfile_sb #(
      .REGISTER_WIDTH      (W),
      .REGISTER_ADDR_WIDTH (AW),
      .NUM_RD              (NR),
      .NUM_WR              (NW),
      .INIT_STYLE          (1)
   ) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .flush     (flush),
      .ready     (ready)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      string           name;
      logic [NR*W-1:0] rd_data;
      logic [NR-1:0]   rd_busy;
      logic            ready;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Behavioural reference state
   logic [W-1:0] m_mem [D];
   bit           m_busy [D];
   bit           m_ready;
   int           m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare whatever the DUT shows against the oldest expectation.
   always @(negedge cpu_clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.name, ".ready"},   64'(ready),   64'(e.ready));
         chk({e.name, ".rd_data"}, 64'(rd_data), 64'(e.rd_data));
         chk({e.name, ".rd_busy"}, 64'(rd_busy), 64'(e.rd_busy));
      end
   end

   task automatic model_reset();
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
   endtask

   // One clock edge of the reference: init sweep or architectural update.
   task automatic model_edge();
      int a;
      if (!m_ready) begin
         m_mem[m_cnt] = W'(m_cnt * 3);
         m_cnt++;
         if (m_cnt == D) m_ready = 1'b1;
      end else begin
         for (int j = 0; j < NW; j++) begin
            a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j] && a != 0) begin
               m_mem[a]  = wr_data[j*W +: W];
               m_busy[a] = 1'b0;
            end
         end
         if (flush) begin
            for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
         end else if (iss_valid && iss_addr != 0) begin
            m_busy[iss_addr] = 1'b1;
         end
      end
   endtask

   // Expected outputs for the inputs currently applied.
   task automatic push(input string name);
      exp_t e;
      int   a;
      bit   hit;
      logic [W-1:0] v;
      e.name    = name;
      e.ready   = m_ready;
      e.rd_data = '0;
      e.rd_busy = '0;
      if (m_ready) begin
         for (int k = 0; k < NR; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            if (a != 0) begin
               v   = m_mem[a];
               hit = 1'b0;
               for (int j = NW - 1; j >= 0; j--) begin
                  if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                     v   = wr_data[j*W +: W];
                     hit = 1'b1;
                     break;
                  end
               end
               e.rd_data[k*W +: W] = v;
               e.rd_busy[k]        = m_busy[a] && !hit;
            end
         end
      end
      sb_q.push_back(e);
   endtask

   task automatic drive(input string name);
      if (cpu_rst) model_reset();
      push(name);
   endtask

   task automatic step();
      @(posedge cpu_clk);
      if (!cpu_rst) model_edge();
      #1;
   endtask

   task automatic cyc(input string name);
      drive(name);
      step();
   endtask

   task automatic idle();
      wr_en     = '0;
      iss_valid = 1'b0;
      flush     = 1'b0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, D - 1));
   endfunction

   task automatic rand_inputs();
      rd_addr   = {rand_addr(), rand_addr()};
      wr_en     = NW'($urandom_range(0, 3));
      wr_addr   = {rand_addr(), rand_addr()};
      wr_data   = {$urandom(), $urandom()};
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_addr  = rand_addr();
      flush     = ($urandom_range(0, 7) == 0);
   endtask

   task automatic init_sweep(input string name);
      for (int i = 0; i < D; i++) begin
         rand_inputs();
         cyc(name);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_rst  = 1'b1;
      idle();
      rd_addr  = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_addr = '0;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      model_reset();
      @(posedge cpu_clk);
      #1;
      cyc("reset0");
      rand_inputs();
      drive("reset1");
      #2;
      chk("reset.ready", 64'(ready), 64'(0));
      chk("reset.rd_data", 64'(rd_data), 64'(0));
      step();
      idle();

      // Release reset; junk traffic during INIT must be ignored
      cpu_rst = 1'b0;
      init_sweep("init");

      // x5 = 5*3 after init, x0 reads 0
      idle();
      rd_addr = {5'd0, 5'd5};
      drive("init_vals");
      #2;
      chk("x5_init", 64'(rd_data[W-1:0]), 64'd15);
      chk("x0_init", 64'(rd_data[2*W-1:W]), 64'd0);
      chk("ready_up", 64'(ready), 64'd1);
      step();

      // Two ports write x3 together: port 1 wins, bypassed the same cycle
      rd_addr = {5'd0, 5'd3};
      wr_en   = 2'b11;
      wr_addr = {5'd3, 5'd3};
      wr_data = {32'h5555, 32'hAAAA};
      drive("wr_collide");
      #2;
      chk("x3_bypass", 64'(rd_data[W-1:0]), 64'h5555);
      step();
      idle();
      drive("wr_collide_next");
      #2;
      chk("x3_stored", 64'(rd_data[W-1:0]), 64'h5555);
      step();

      // Issue x7, idle, then write back x7 = 9
      iss_valid = 1'b1;
      iss_addr  = 5'd7;
      rd_addr   = {5'd0, 5'd7};
      cyc("iss7");
      idle();
      cyc("idle7a");
      cyc("idle7b");
      drive("idle7c");
      #2;
      chk("x7_busy", 64'(rd_busy[0]), 64'd1);
      step();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd7};
      wr_data = {32'd0, 32'd9};
      drive("wb7");
      #2;
      chk("x7_wb_busy", 64'(rd_busy[0]), 64'd0);
      chk("x7_wb_data", 64'(rd_data[W-1:0]), 64'd9);
      step();
      idle();
      drive("wb7_next");
      #2;
      chk("x7_after_busy", 64'(rd_busy[0]), 64'd0);
      step();

      // Issue and write x4 together: set wins; then again with flush
      iss_valid = 1'b1;
      iss_addr  = 5'd4;
      wr_en     = 2'b10;
      wr_addr   = {5'd4, 5'd0};
      wr_data   = {32'h44, 32'h0};
      rd_addr   = {5'd0, 5'd4};
      cyc("iss_wr4");
      idle();
      drive("iss_wr4_next");
      #2;
      chk("x4_busy", 64'(rd_busy[0]), 64'd1);
      chk("x4_data", 64'(rd_data[W-1:0]), 64'h44);
      step();
      iss_valid = 1'b1;
      flush     = 1'b1;
      wr_en     = 2'b10;
      wr_data   = {32'h55, 32'h0};
      cyc("flush4");
      idle();
      drive("flush4_next");
      #2;
      chk("x4_flushed_busy", 64'(rd_busy[0]), 64'd0);
      chk("x4_flushed_data", 64'(rd_data[W-1:0]), 64'h55);
      step();

      // x0 ignores writes and issues
      wr_en     = 2'b01;
      wr_addr   = {5'd0, 5'd0};
      wr_data   = {32'd0, 32'hFFFF};
      iss_valid = 1'b1;
      iss_addr  = 5'd0;
      rd_addr   = {5'd0, 5'd0};
      drive("x0_wr");
      #2;
      chk("x0_data", 64'(rd_data[W-1:0]), 64'd0);
      chk("x0_busy", 64'(rd_busy[0]), 64'd0);
      step();
      idle();
      drive("x0_next");
      #2;
      chk("x0_data_next", 64'(rd_data[W-1:0]), 64'd0);
      chk("x0_busy_next", 64'(rd_busy[0]), 64'd0);
      step();

      // Reset mid-RUN with x2 busy
      iss_valid = 1'b1;
      iss_addr  = 5'd2;
      cyc("iss2");
      idle();
      rd_addr = {5'd2, 5'd0};
      drive("x2_busy");
      #2;
      chk("x2_busy", 64'(rd_busy[1]), 64'd1);
      step();
      cpu_rst = 1'b1;
      drive("rst_mid");
      #2;
      chk("rst_mid.ready", 64'(ready), 64'd0);
      chk("rst_mid.rd_busy", 64'(rd_busy), 64'd0);
      step();
      cyc("rst_hold");
      cpu_rst = 1'b0;
      init_sweep("reinit");
      idle();
      rd_addr = {5'd2, 5'd5};
      drive("reinit_done");
      #2;
      chk("reinit.ready", 64'(ready), 64'd1);
      chk("reinit.x2_busy", 64'(rd_busy[1]), 64'd0);
      chk("reinit.x5", 64'(rd_data[W-1:0]), 64'd15);
      step();

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         cpu_rst = ($urandom_range(0, 199) == 0);
         cyc("rand");
      end
      cpu_rst = 1'b0;
      idle();
      for (int i = 0; i < 40; i++) begin
         rd_addr = {rand_addr(), rand_addr()};
         cyc("tail");
      end

      @(negedge cpu_clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
